tile_match_ctrl: RTL and testbench
==================================

Name: tile_match_ctrl

Overview:
- Game-side responder to the per-tile click/cover logic.
- Collects "tile revealed" events from all tile cover blocks and compares the pair IDs of two revealed tiles.
- On a match, marks both tiles permanently matched. On a mismatch, waits a visible delay, then commands both tiles back to covered.
- Sits between the tile cover blocks and the score/end-screen logic in the draw_image path.

Parameters:
- N_TILES, 12, number of tiles on the board (must be even).
- ID_W, 3, width of a tile's pair ID.
- HIDE_DELAY, 65_000_000, cycles a mismatched pair stays visible (1 s at 65 MHz).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- reveal_evt  in  N_TILES  one-cycle pulse per tile when it switches covered→revealed.
- cover_evt  in  N_TILES  one-cycle pulse per tile when the user re-covers it.
- tile_id  in  N_TILES*ID_W  packed pair ID per tile; tile i is at bits [i*ID_W +: ID_W]. Static during play.
- hide_req  out  N_TILES  one-cycle pulse forcing the tile to its covered state.
- matched  out  N_TILES  level; tile is permanently revealed and its clicks are ignored.
- lock  out  1  high while comparing or waiting; tile blocks must ignore clicks.
- pairs_found  out  $clog2(N_TILES/2+1)  count of matched pairs.
- game_done  out  1  level, high once all pairs are matched.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; hide_req=0, matched=0, lock=0, pairs_found=0, game_done=0; delay counter=0; first/second index registers=0.
- Event qualification: a reveal_evt bit counts only if lock=0 and matched[i]=0. If several qualified bits are high in one cycle, the lowest index is taken and the others are dropped.
- IDLE:
  - On a qualified reveal of tile a: latch first=a, go to ONE.
- ONE:
  - On cover_evt[first]: go to IDLE (user undid the reveal).
  - On a qualified reveal of b≠first: latch second=b, go to CMP. lock goes high in the same edge that enters CMP.
  - A reveal_evt of first itself is ignored.
  - If cover_evt[first] and a qualified reveal arrive in the same cycle: the cover wins, go to IDLE, and the reveal is dropped.
- CMP (one cycle, lock=1):
  - If tile_id[first]==tile_id[second]: set matched[first] and matched[second], increment pairs_found, go to IDLE.
  - Otherwise: load the delay counter with HIDE_DELAY-1 and go to WAIT.
  - lock=0 in the cycle after a match.
  - If the increment makes pairs_found equal N_TILES/2, go to DONE instead of IDLE.
- WAIT (lock=1): decrement the counter each cycle. When the counter reaches 0, go to HIDE. All reveal_evt and cover_evt inputs are ignored.
- HIDE (one cycle, lock=1): hide_req[first] and hide_req[second] are high for exactly this cycle; go to IDLE. lock=0 from the next cycle.
- DONE: game_done=1, lock=1, absorbing; only reset exits.
- Latency:
  - Second reveal to matched: 2 edges.
  - Second reveal to hide_req pulse: HIDE_DELAY+2 edges.
- Outputs hide_req, lock and game_done are registered; no combinational path from any input to any output.
- Reset mid-WAIT: counter and state clear; tiles are not hidden by this block (the tile blocks reset themselves).
- pairs_found saturates at N_TILES/2 and never wraps.

Decomposition:
- Shared vga_pkg additions:
  - TILE_CNT and TILE_ID_W constants.
  - typedef tile_match_state_t enum {IDLE, ONE, CMP, WAIT, HIDE, DONE}, one-hot encoded.
  - Default HIDE_DELAY derived from the pixel clock frequency.
- One sub-module: lowest_set_idx, a parameterised priority encoder over N_TILES bits with outputs idx and valid. It is used on the qualified reveal vector.

Test Plan (HIDE_DELAY=4, N_TILES=4, tile_id={0,1,0,1} for tiles 0..3):
- Reveal tile 0, then tile 2 → matched=4'b0101 two edges after the tile 2 pulse; pairs_found=1; hide_req stays 0; lock high for exactly 1 cycle.
- Reveal tile 0, then tile 1 → lock high; hide_req=4'b0011 for one cycle, 6 edges after the tile 1 pulse; lock=0 the next cycle.
- During WAIT, pulse reveal_evt[3] → no effect: state and index registers unchanged, same hide_req timing.
- Reveal tile 0, pulse cover_evt[0], then reveal tiles 1 and 3 → back to IDLE after the cover; tiles 1 and 3 match with pairs_found=1; tile 0 is never hidden.
- reveal_evt=4'b1010 in one cycle from IDLE → first=1 and tile 3 dropped. Then reveal tile 3 → match, matched=4'b1010.
- Match both pairs → pairs_found=2, game_done=1, lock=1. Further reveal_evt are ignored. rst_n low for one edge clears all outputs to 0.

Source files
------------

// File: rtl/tile_match_ctrl_pkg.sv
// Shared constants and types for the tile matching controller.
//   TILE_CNT / TILE_ID_W : default board size and pair-ID width
//   HIDE_DELAY_DEFAULT   : cycles a mismatched pair stays visible (1 s of pixel clock)
//   tile_match_state_t   : one-hot FSM state encoding
package tile_match_ctrl_pkg;

  localparam int TILE_CNT           = 12;
  localparam int TILE_ID_W          = 3;
  localparam int PIX_CLK_HZ         = 65_000_000;
  localparam int HIDE_DELAY_DEFAULT = PIX_CLK_HZ;

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    ONE  = 6'b000010,
    CMP  = 6'b000100,
    WAIT = 6'b001000,
    HIDE = 6'b010000,
    DONE = 6'b100000
  } tile_match_state_t;

  // Width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tile_match_ctrl_lowest_set_idx.sv
// Priority encoder: reports the index of the lowest set bit of vec.
//   vec   : input vector
//   idx   : index of lowest set bit (0 when none set)
//   valid : at least one bit of vec is set
module lowest_set_idx
  import tile_match_ctrl_pkg::*;
#(
  parameter int N     = 12,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_match_ctrl.sv
// Tile matching controller: pairs up revealed tiles, marks matches, and
// re-covers mismatched pairs after a visible delay.
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   reveal_evt  : per-tile pulse, covered -> revealed
//   cover_evt   : per-tile pulse, user re-covered the tile
//   tile_id     : packed pair ID per tile (tile i at [i*ID_W +: ID_W])
//   hide_req    : per-tile pulse forcing the tile back to covered
//   matched     : per-tile level, tile permanently matched
//   lock        : tile blocks must ignore clicks while high
//   pairs_found : number of matched pairs
//   game_done   : all pairs matched
//
// state | meaning
// IDLE  | no tile pending
// ONE   | first tile revealed, waiting for second
// CMP   | comparing pair IDs (one cycle)
// WAIT  | mismatch visible, delay counting down
// HIDE  | hide_req pulse for both tiles (one cycle)
// DONE  | all pairs matched, absorbing
module tile_match_ctrl
  import tile_match_ctrl_pkg::*;
#(
  parameter int N_TILES    = TILE_CNT,
  parameter int ID_W       = TILE_ID_W,
  parameter int HIDE_DELAY = HIDE_DELAY_DEFAULT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_TILES-1:0]                 reveal_evt,
  input  logic [N_TILES-1:0]                 cover_evt,
  input  logic [N_TILES*ID_W-1:0]            tile_id,
  output logic [N_TILES-1:0]                 hide_req,
  output logic [N_TILES-1:0]                 matched,
  output logic                               lock,
  output logic [$clog2(N_TILES/2+1)-1:0]     pairs_found,
  output logic                               game_done
);

  localparam int IDX_W = clog2_min1(N_TILES);
  localparam int CNT_W = clog2_min1(HIDE_DELAY);
  localparam int PF_W  = $clog2(N_TILES/2+1);
  localparam logic [PF_W-1:0]    HALF = PF_W'(N_TILES/2);
  localparam logic [N_TILES-1:0] LSB  = {{(N_TILES-1){1'b0}}, 1'b1};

  tile_match_state_t state, state_d;
  logic [IDX_W-1:0]   first, first_d, second, second_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [N_TILES-1:0] matched_d, hide_d;
  logic [PF_W-1:0]    pairs_d;
  logic               lock_d, done_d;

  logic [ID_W-1:0]    ids [N_TILES];
  logic [N_TILES-1:0] first_oh, second_oh, qual;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;

  for (genvar g = 0; g < N_TILES; g++) begin : g_ids
    assign ids[g] = tile_id[g*ID_W +: ID_W];
  end

  assign first_oh  = LSB << first;
  assign second_oh = LSB << second;

  // While one tile is pending, a repeat reveal of it must not count as the second.
  assign qual = reveal_evt & ~matched & {N_TILES{~lock}} &
                ~((state == ONE) ? first_oh : '0);

  lowest_set_idx #(.N(N_TILES), .IDX_W(IDX_W)) u_enc (
    .vec   (qual),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      first       <= '0;
      second      <= '0;
      cnt         <= '0;
      matched     <= '0;
      pairs_found <= '0;
      hide_req    <= '0;
      lock        <= 1'b0;
      game_done   <= 1'b0;
    end else begin
      state       <= state_d;
      first       <= first_d;
      second      <= second_d;
      cnt         <= cnt_d;
      matched     <= matched_d;
      pairs_found <= pairs_d;
      hide_req    <= hide_d;
      lock        <= lock_d;
      game_done   <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    first_d   = first;
    second_d  = second;
    cnt_d     = cnt;
    matched_d = matched;
    pairs_d   = pairs_found;
    hide_d    = '0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          first_d = enc_idx;
          state_d = ONE;
        end
      end
      ONE: begin
        // A cover of the pending tile beats any simultaneous reveal.
        if (cover_evt[first]) begin
          state_d = IDLE;
        end else if (enc_valid) begin
          second_d = enc_idx;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (ids[first] == ids[second]) begin
          matched_d = matched | first_oh | second_oh;
          if (pairs_found < HALF) pairs_d = pairs_found + PF_W'(1);
          state_d = (pairs_found + PF_W'(1) == HALF) ? DONE : IDLE;
        end else begin
          cnt_d   = CNT_W'(HIDE_DELAY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          hide_d  = first_oh | second_oh;
          state_d = HIDE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      HIDE:    state_d = IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    lock_d = (state_d == CMP) || (state_d == WAIT) ||
             (state_d == HIDE) || (state_d == DONE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_tile_match_ctrl.sv
module tb_tile_match_ctrl;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int HD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  reveal_evt = '0;
  logic [N-1:0]  cover_evt = '0;
  logic [N*IW-1:0] tile_id;
  logic [N-1:0]  hide_req;
  logic [N-1:0]  matched;
  logic          lock;
  logic [1:0]    pairs_found;
  logic          game_done;

  int n_pass = 0;
  int n_total = 0;

  // Model state: pair ID of each tile.
  int ids [N];

  tile_match_ctrl #(.N_TILES(N), .ID_W(IW), .HIDE_DELAY(HD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reveal_evt  (reveal_evt),
    .cover_evt   (cover_evt),
    .tile_id     (tile_id),
    .hide_req    (hide_req),
    .matched     (matched),
    .lock        (lock),
    .pairs_found (pairs_found),
    .game_done   (game_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ids(input int i0, input int i1, input int i2, input int i3);
    ids[0] = i0; ids[1] = i1; ids[2] = i2; ids[3] = i3;
    for (int i = 0; i < N; i++) tile_id[i*IW +: IW] = IW'(ids[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reveal_evt = '0;
    cover_evt = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_rev(input logic [N-1:0] v);
    reveal_evt = v;
    step();
    reveal_evt = '0;
  endtask

  task automatic test_reset();
    set_ids(0, 1, 0, 1);
    do_reset();
    n_total++; if (hide_req !== 4'b0) $display("FAIL reset_hide_req got %b want 0000", hide_req); else n_pass++;
    n_total++; if (matched !== 4'b0) $display("FAIL reset_matched got %b want 0000", matched); else n_pass++;
    n_total++; if (lock !== 1'b0) $display("FAIL reset_lock got %b want 0", lock); else n_pass++;
    n_total++; if (pairs_found !== 2'd0) $display("FAIL reset_pairs got %0d want 0", pairs_found); else n_pass++;
    n_total++; if (game_done !== 1'b0) $display("FAIL reset_done got %b want 0", game_done); else n_pass++;
  endtask

  task automatic test_match();
    set_ids(0, 1, 0, 1);
    do_reset();
    pulse_rev(4'b0001);
    n_total++; if (lock !== 1'b0) $display("FAIL match_lock_one got %b want 0", lock); else n_pass++;
    pulse_rev(4'b0100);
    n_total++; if (lock !== 1'b1) $display("FAIL match_lock_cmp got %b want 1", lock); else n_pass++;
    n_total++; if (matched !== 4'b0000) $display("FAIL match_early got %b want 0000", matched); else n_pass++;
    step();
    n_total++; if (matched !== 4'b0101) $display("FAIL match_matched got %b want 0101", matched); else n_pass++;
    n_total++; if (pairs_found !== 2'd1) $display("FAIL match_pairs got %0d want 1", pairs_found); else n_pass++;
    n_total++; if (lock !== 1'b0) $display("FAIL match_lock_after got %b want 0", lock); else n_pass++;
    n_total++; if (hide_req !== 4'b0) $display("FAIL match_hide got %b want 0000", hide_req); else n_pass++;
  endtask

  // Mismatch of tiles 0 and 1; optionally inject ignored events during WAIT.
  task automatic run_mismatch(input bit inject);
    logic [N-1:0] exp_hide;
    logic exp_lock;
    set_ids(0, 1, 0, 1);
    do_reset();
    pulse_rev(4'b0001);
    pulse_rev(4'b0010);
    for (int k = 1; k <= HD + 2; k++) begin
      if (inject && k == 2) begin
        reveal_evt = 4'b1000;
        cover_evt  = 4'b0001;
      end
      step();
      reveal_evt = '0;
      cover_evt  = '0;
      exp_hide = (k == HD + 1) ? 4'b0011 : 4'b0000;
      exp_lock = (k <= HD + 1);
      n_total++; if (hide_req !== exp_hide) $display("FAIL mismatch_hide edge %0d inj %0d got %b want %b", k + 1, inject, hide_req, exp_hide); else n_pass++;
      n_total++; if (lock !== exp_lock) $display("FAIL mismatch_lock edge %0d inj %0d got %b want %b", k + 1, inject, lock, exp_lock); else n_pass++;
    end
    n_total++; if (matched !== 4'b0) $display("FAIL mismatch_matched got %b want 0000", matched); else n_pass++;
    if (inject) begin
      // Back in IDLE with no pending tile: 3 then 1 must match.
      pulse_rev(4'b1000);
      pulse_rev(4'b0010);
      step();
      n_total++; if (matched !== 4'b1010) $display("FAIL wait_ignore_after got %b want 1010", matched); else n_pass++;
    end
  endtask

  task automatic test_cover_undo();
    bit saw_hide;
    set_ids(0, 1, 0, 1);
    do_reset();
    saw_hide = 0;
    pulse_rev(4'b0001);
    cover_evt = 4'b0001;
    step();
    cover_evt = '0;
    pulse_rev(4'b0010);
    n_total++; if (lock !== 1'b0) $display("FAIL cover_lock got %b want 0", lock); else n_pass++;
    pulse_rev(4'b1000);
    step();
    n_total++; if (matched !== 4'b1010) $display("FAIL cover_matched got %b want 1010", matched); else n_pass++;
    n_total++; if (pairs_found !== 2'd1) $display("FAIL cover_pairs got %0d want 1", pairs_found); else n_pass++;
    for (int k = 0; k < HD + 4; k++) begin
      if (hide_req !== 4'b0) saw_hide = 1;
      step();
    end
    n_total++; if (saw_hide !== 1'b0) $display("FAIL cover_no_hide got %b want 0", saw_hide); else n_pass++;
  endtask

  task automatic test_cover_wins();
    set_ids(0, 1, 0, 1);
    do_reset();
    pulse_rev(4'b0001);
    cover_evt  = 4'b0001;
    reveal_evt = 4'b0100;
    step();
    cover_evt  = '0;
    reveal_evt = '0;
    n_total++; if (lock !== 1'b0) $display("FAIL cover_wins_lock got %b want 0", lock); else n_pass++;
    pulse_rev(4'b0100);
    pulse_rev(4'b0001);
    step();
    n_total++; if (matched !== 4'b0101) $display("FAIL cover_wins_match got %b want 0101", matched); else n_pass++;
  endtask

  task automatic test_multi_reveal();
    set_ids(0, 1, 0, 1);
    do_reset();
    pulse_rev(4'b1010);
    n_total++; if (lock !== 1'b0) $display("FAIL multi_lock got %b want 0", lock); else n_pass++;
    pulse_rev(4'b1000);
    n_total++; if (lock !== 1'b1) $display("FAIL multi_lock_cmp got %b want 1", lock); else n_pass++;
    step();
    n_total++; if (matched !== 4'b1010) $display("FAIL multi_matched got %b want 1010", matched); else n_pass++;
  endtask

  task automatic test_done();
    set_ids(0, 1, 0, 1);
    do_reset();
    pulse_rev(4'b0001); pulse_rev(4'b0100); step();
    pulse_rev(4'b0010); pulse_rev(4'b1000); step();
    n_total++; if (pairs_found !== 2'd2) $display("FAIL done_pairs got %0d want 2", pairs_found); else n_pass++;
    n_total++; if (game_done !== 1'b1) $display("FAIL done_flag got %b want 1", game_done); else n_pass++;
    n_total++; if (lock !== 1'b1) $display("FAIL done_lock got %b want 1", lock); else n_pass++;
    n_total++; if (matched !== 4'b1111) $display("FAIL done_matched got %b want 1111", matched); else n_pass++;
    pulse_rev(4'b1111);
    pulse_rev(4'b0011);
    for (int k = 0; k < HD + 3; k++) step();
    n_total++; if (hide_req !== 4'b0 || pairs_found !== 2'd2 || game_done !== 1'b1 || lock !== 1'b1)
      $display("FAIL done_absorb got hide %b pairs %0d done %b lock %b want 0000 2 1 1", hide_req, pairs_found, game_done, lock); else n_pass++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_total++; if (matched !== 4'b0 || pairs_found !== 2'd0 || game_done !== 1'b0 || lock !== 1'b0 || hide_req !== 4'b0)
      $display("FAIL done_reset got m %b p %0d d %b l %b h %b want all 0", matched, pairs_found, game_done, lock, hide_req); else n_pass++;
  endtask

  // Random boards and random play, checked against a board-level model.
  task automatic test_random_games();
    int id0, id1, a, b, t, cnt_u, waited;
    int unm [N];
    int perm [N];
    logic [N-1:0] m;
    int pm;
    for (int g = 0; g < 8; g++) begin
      id0 = $urandom_range(0, 7);
      id1 = (id0 + 1 + $urandom_range(0, 6)) % 8;
      perm[0] = id0; perm[1] = id0; perm[2] = id1; perm[3] = id1;
      for (int i = N - 1; i > 0; i--) begin
        int j, tmp;
        j = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      set_ids(perm[0], perm[1], perm[2], perm[3]);
      do_reset();
      m = '0;
      pm = 0;
      for (int mv = 0; mv < 30 && pm < 2; mv++) begin
        if (m != 0 && $urandom_range(0, 3) == 0) begin
          do t = $urandom_range(0, N - 1); while (!m[t]);
          pulse_rev(N'(1 << t));
        end
        cnt_u = 0;
        for (int i = 0; i < N; i++) if (!m[i]) begin unm[cnt_u] = i; cnt_u++; end
        a = unm[$urandom_range(0, cnt_u - 1)];
        do b = unm[$urandom_range(0, cnt_u - 1)]; while (b == a);
        pulse_rev(N'(1 << a));
        pulse_rev(N'(1 << b));
        n_total++; if (lock !== 1'b1) $display("FAIL rnd_lock game %0d tiles %0d,%0d got %b want 1", g, a, b, lock); else n_pass++;
        if (ids[a] == ids[b]) begin
          step();
          m = m | N'(1 << a) | N'(1 << b);
          pm++;
          n_total++; if (matched !== m || pairs_found !== 2'(pm) || game_done !== (pm == 2) || lock !== (pm == 2))
            $display("FAIL rnd_match game %0d got m %b p %0d d %b l %b want m %b p %0d", g, matched, pairs_found, game_done, lock, m, pm); else n_pass++;
        end else begin
          waited = 0;
          while (hide_req === 4'b0 && waited < 20) begin
            step();
            waited++;
          end
          n_total++; if (waited != HD + 1 || hide_req !== (N'(1 << a) | N'(1 << b)))
            $display("FAIL rnd_hide game %0d got edges %0d hide %b want edges %0d hide %b", g, waited + 1, hide_req, HD + 2, N'(1 << a) | N'(1 << b)); else n_pass++;
          step();
          n_total++; if (lock !== 1'b0 || matched !== m)
            $display("FAIL rnd_after_hide game %0d got l %b m %b want 0 %b", g, lock, matched, m); else n_pass++;
        end
      end
      n_total++; if (game_done !== 1'b1) $display("FAIL rnd_game_done game %0d got %b want 1", g, game_done); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_match();
    run_mismatch(1'b0);
    run_mismatch(1'b1);
    test_cover_undo();
    test_cover_wins();
    test_multi_reveal();
    test_done();
    test_random_games();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
